// File: rtl/parking_pkg.sv
// Shared types for the parking lane arbiter: FSM state encodings, lane identifiers
// and the default gate PIN.
package parking_pkg;

    localparam logic [7:0] PIN_CORRECTO_DEFAULT = 8'h10;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        SERVE   = 4'b0010,
        OPEN    = 4'b0100,
        BLOCKED = 4'b1000
    } state_t;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_t;

    function automatic lane_t other_lane(input lane_t l);
        return (l == LANE_A) ? LANE_B : LANE_A;
    endfunction

endpackage

// File: rtl/parking_lane_arbiter_if.sv
// Lane sensors, PIN pads and gate indications shared between the arbiter and its environment.
interface parking_lane_arbiter_if;

    logic       Vehiculo_A;
    logic       Vehiculo_B;
    logic       enterPin_A;
    logic       enterPin_B;
    logic [7:0] Pin_A;
    logic [7:0] Pin_B;
    logic       Termino;
    logic       Grant_A;
    logic       Grant_B;
    logic       Cerrado;
    logic       Abierto;
    logic       Alarma;
    logic       Bloqueo;

    modport master (
        output Vehiculo_A, Vehiculo_B, enterPin_A, enterPin_B, Pin_A, Pin_B, Termino,
        input  Grant_A, Grant_B, Cerrado, Abierto, Alarma, Bloqueo
    );

    modport slave (
        input  Vehiculo_A, Vehiculo_B, enterPin_A, enterPin_B, Pin_A, Pin_B, Termino,
        output Grant_A, Grant_B, Cerrado, Abierto, Alarma, Bloqueo
    );

endinterface

// File: rtl/lane_fail_counter.sv
// Per-lane failed-PIN counter: saturates at MAX, cleared by a correct PIN or Reset.
module lane_fail_counter #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] count;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + W'(1);
        end
    end

    assign at_max = (count == W'(MAX));

endmodule

// File: rtl/parking_lane_arbiter.sv
// Round-robin arbiter sharing one parking gate between lanes A and B, with PIN check,
// tailgating block and a stall timeout on the granted lane.
module parking_lane_arbiter
    import parking_pkg::*;
#(
    parameter logic [7:0] PIN_CORRECTO = PIN_CORRECTO_DEFAULT,
    parameter int         MAX_FAILS    = 3,
    parameter int         TIMEOUT      = 16
) (
    input logic                  Clk,
    input logic                  Reset,
    parking_lane_arbiter_if.slave bus
);

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TW     = $clog2(TIMEOUT);

    state_t        state;
    lane_t         g;
    lane_t         prio;
    logic [TW-1:0] timer;

    logic       veh_g;
    logic       strobe_g;
    logic [7:0] pin_g;
    logic       pin_ok;
    logic       pin_bad;
    logic       max_a;
    logic       max_b;
    logic       max_g;
    logic       clr_g;
    logic       inc_g;

    // Everything below looks only at the granted lane; the other lane's strobes never reach it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        veh_g    = bus.Vehiculo_A;
        strobe_g = bus.enterPin_A;
        pin_g    = bus.Pin_A;
        max_g    = max_a;
        if (g == LANE_B) begin
            veh_g    = bus.Vehiculo_B;
            strobe_g = bus.enterPin_B;
            pin_g    = bus.Pin_B;
            max_g    = max_b;
        end
    end

    assign pin_ok  = strobe_g && (pin_g == PIN_CORRECTO);
    assign pin_bad = strobe_g && (pin_g != PIN_CORRECTO);
    assign clr_g   = ((state == SERVE) && veh_g && pin_ok) || ((state == BLOCKED) && pin_ok);
    assign inc_g   = (state == SERVE) && veh_g && pin_bad;

    lane_fail_counter #(.MAX(MAX_FAILS), .W(FAIL_W)) u_fail_a (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr    (clr_g && (g == LANE_A)),
        .inc    (inc_g && (g == LANE_A)),
        .at_max (max_a)
    );

    lane_fail_counter #(.MAX(MAX_FAILS), .W(FAIL_W)) u_fail_b (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr    (clr_g && (g == LANE_B)),
        .inc    (inc_g && (g == LANE_B)),
        .at_max (max_b)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            g     <= LANE_A;
            prio  <= LANE_A;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (bus.Vehiculo_A && bus.Vehiculo_B) begin
                        g     <= prio;
                        state <= SERVE;
                    end else if (bus.Vehiculo_A) begin
                        g     <= LANE_A;
                        state <= SERVE;
                    end else if (bus.Vehiculo_B) begin
                        g     <= LANE_B;
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    timer <= timer + TW'(1);
                    if (!veh_g) begin
                        state <= IDLE;
                        prio  <= other_lane(g);
                        timer <= '0;
                    end else if (pin_ok) begin
                        state <= OPEN;
                        timer <= '0;
                    end else if (pin_bad) begin
                        timer <= '0;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state <= IDLE;
                        prio  <= other_lane(g);
                        timer <= '0;
                    end
                end
                OPEN: begin
                    timer <= '0;
                    if (bus.Termino) begin
                        if (veh_g) begin
                            state <= BLOCKED;
                        end else begin
                            state <= IDLE;
                            prio  <= other_lane(g);
                        end
                    end
                end
                BLOCKED: begin
                    timer <= '0;
                    if (pin_ok) state <= OPEN;
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Moore decode: depends only on state, g and the registered fail counters.
    always_comb begin
        bus.Grant_A = 1'b0;
        bus.Grant_B = 1'b0;
        bus.Cerrado = 1'b0;
        bus.Abierto = 1'b0;
        bus.Alarma  = 1'b0;
        bus.Bloqueo = 1'b0;
        case (state)
            IDLE: bus.Cerrado = 1'b1;
            SERVE: begin
                bus.Cerrado = 1'b1;
                bus.Alarma  = max_g;
            end
            OPEN:    bus.Abierto = 1'b1;
            BLOCKED: begin
                bus.Alarma  = 1'b1;
                bus.Bloqueo = 1'b1;
            end
            default: ;
        endcase
        if (state == SERVE || state == OPEN || state == BLOCKED) begin
            bus.Grant_A = (g == LANE_A);
            bus.Grant_B = (g == LANE_B);
        end
    end

endmodule
